// File: rtl/axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi4_slave_mem
// Brief    : AXI4 slave backed by a word-addressed on-chip RAM. It accepts one
//            outstanding write and one outstanding read on independent
//            channels, with FIXED/INCR bursts of up to 16 beats. Defining
//            AXI_SLV_WRAP_BURST_EN also enables WRAP bursts.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    ARESET,
    // write address
    input  logic [8:0]              AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // write data
    input  logic [8:0]              WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // write response
    output logic [8:0]              BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    // read address
    input  logic [8:0]              ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // read data
    output logic [8:0]              RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int          c_strb_w     = DATA_WIDTH / 8;
    localparam int          c_bsh        = $clog2(c_strb_w);
    localparam int          c_aw         = $clog2(MEM_DEPTH);
    localparam logic [2:0]  c_max_size   = 3'(c_bsh);
    localparam logic [1:0]  c_burst_fixed = 2'b00;
    localparam logic [1:0]  c_burst_wrap  = 2'b10;
    localparam logic [1:0]  c_burst_rsvd  = 2'b11;
    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;
`ifdef AXI_SLV_WRAP_BURST_EN
    localparam logic        c_wrap_en    = 1'b1;
`else
    localparam logic        c_wrap_en    = 1'b0;
`endif

    localparam logic [1:0]  c_w_idle = 2'd0;
    localparam logic [1:0]  c_w_data = 2'd1;
    localparam logic [1:0]  c_w_resp = 2'd2;
    localparam logic        c_r_idle = 1'b0;
    localparam logic        c_r_data = 1'b1;

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> (c_bsh + c_aw)) == '0;
    endfunction

    function automatic logic f_illegal(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [3:0]            len,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] align_mask;
        logic                  wrap_ok;
        align_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        wrap_ok    = (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) &&
                     ((addr & align_mask) == '0);
        return (size > c_max_size) || (burst == c_burst_rsvd) ||
               ((burst == c_burst_wrap) && !(c_wrap_en && wrap_ok));
    endfunction

    // WRAP keeps the bits above the (LEN+1)<<SIZE window and wraps the rest
    function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [3:0]            len,
                                                     input logic [2:0]            size,
                                                     input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr + (ADDR_WIDTH'(1) << size);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        if (burst == c_burst_fixed)
            return addr;
        else if (c_wrap_en && burst == c_burst_wrap)
            return (addr & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    logic                    r_live;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------ write
    logic [1:0]              r_wstate;
    logic [1:0]              w_wstate_nxt;
    logic [8:0]              r_awid;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [3:0]              r_wlen;
    logic [2:0]              r_wsize;
    logic [1:0]              r_wburst;
    logic [3:0]              r_wcnt;
    logic                    r_wbad;
    logic                    r_werr;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_w_end;
    logic                    w_w_inrange;
    logic                    w_beat_err;
    logic                    w_we;
    logic [c_aw-1:0]         w_widx;

    assign w_aw_hs     = AWVALID & AWREADY;
    assign w_w_hs      = WVALID & WREADY;
    assign w_b_hs      = BVALID & BREADY;
    assign w_w_end     = w_w_hs & (WLAST | (r_wcnt == r_wlen));
    assign w_w_inrange = f_in_range(r_waddr);
    assign w_beat_err  = !w_w_inrange | (WLAST & (r_wcnt != r_wlen)) |
                         (!WLAST & (r_wcnt == r_wlen));
    assign w_we        = w_w_hs & !r_wbad & w_w_inrange;
    assign w_widx      = r_waddr[c_bsh +: c_aw];

    always_ff @(posedge clk) begin
        if (ARESET) begin
            r_wstate <= c_w_idle;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_w_idle: if (w_aw_hs) w_wstate_nxt = c_w_data;
            c_w_data: if (w_w_end) w_wstate_nxt = c_w_resp;
            c_w_resp: if (w_b_hs)  w_wstate_nxt = c_w_idle;
            default:               w_wstate_nxt = c_w_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ARESET) begin
            r_awid   <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_wbad   <= 1'b0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_awid   <= AWID;
            r_waddr  <= AWADDR;
            r_wlen   <= AWLEN;
            r_wsize  <= AWSIZE;
            r_wburst <= AWBURST;
            r_wcnt   <= '0;
            r_wbad   <= f_illegal(AWADDR, AWLEN, AWSIZE, AWBURST);
            r_werr   <= f_illegal(AWADDR, AWLEN, AWSIZE, AWBURST);
        end else if (w_w_hs) begin
            r_wcnt   <= r_wcnt + 4'd1;
            r_waddr  <= f_next(r_waddr, r_wlen, r_wsize, r_wburst);
            r_werr   <= r_werr | w_beat_err;
        end
    end

    // Illegal bursts still consume their beats but never touch the RAM
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (WSTRB[b])
                    r_mem[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign AWREADY = r_live & (r_wstate == c_w_idle);
    assign WREADY  = (r_wstate == c_w_data);
    assign BVALID  = (r_wstate == c_w_resp);
    assign BID     = r_awid;
    assign BRESP   = r_werr ? c_resp_slverr : c_resp_okay;

    // ------------------------------------------------------------------- read
    logic                    r_rstate;
    logic                    w_rstate_nxt;
    logic [8:0]              r_rid;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [3:0]              r_rlen;
    logic [2:0]              r_rsize;
    logic [1:0]              r_rburst;
    logic [3:0]              r_rcnt;
    logic                    r_rbad;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_fetch;
    logic                    w_ar_illegal;
    logic [ADDR_WIDTH-1:0]   w_fetch_addr;
    logic                    w_fetch_err;
    logic [c_aw-1:0]         w_fidx;
    logic [3:0]              w_rcnt_nxt;
    logic [3:0]              w_rlen_nxt;

    assign w_ar_hs      = ARVALID & ARREADY;
    assign w_r_hs       = RVALID & RREADY;
    // A beat is fetched on AR acceptance or when a non-last beat is taken
    assign w_fetch      = w_ar_hs | (w_r_hs & !r_rlast);
    assign w_ar_illegal = f_illegal(ARADDR, ARLEN, ARSIZE, ARBURST);
    assign w_fetch_addr = (r_rstate == c_r_idle) ? ARADDR
                                                 : f_next(r_raddr, r_rlen, r_rsize, r_rburst);
    assign w_fetch_err  = ((r_rstate == c_r_idle) ? w_ar_illegal : r_rbad) |
                          !f_in_range(w_fetch_addr);
    assign w_fidx       = w_fetch_addr[c_bsh +: c_aw];
    assign w_rcnt_nxt   = w_ar_hs ? 4'd0 : r_rcnt + 4'd1;
    assign w_rlen_nxt   = w_ar_hs ? ARLEN : r_rlen;

    always_ff @(posedge clk) begin
        if (ARESET)
            r_rstate <= c_r_idle;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_r_idle: if (w_ar_hs)           w_rstate_nxt = c_r_data;
            c_r_data: if (w_r_hs && r_rlast) w_rstate_nxt = c_r_idle;
            default:                         w_rstate_nxt = c_r_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ARESET) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rbad   <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rid    <= ARID;
                r_rlen   <= ARLEN;
                r_rsize  <= ARSIZE;
                r_rburst <= ARBURST;
                r_rbad   <= w_ar_illegal;
            end
            if (w_fetch) begin
                r_raddr <= w_fetch_addr;
                r_rcnt  <= w_rcnt_nxt;
                r_rlast <= (w_rcnt_nxt == w_rlen_nxt);
                r_rresp <= w_fetch_err ? c_resp_slverr : c_resp_okay;
                r_rdata <= w_fetch_err ? '0 : r_mem[w_fidx];
            end
        end
    end

    assign ARREADY = r_live & (r_rstate == c_r_idle);
    assign RVALID  = (r_rstate == c_r_data);
    assign RID     = r_rid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

    // WID carries no meaning in AXI4
    logic w_unused;
    assign w_unused = ^WID;

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_slave_mem
// Brief    : Directed scoreboard bench for axi4_slave_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_mem;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        ARESET;
    logic [8:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [8:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [8:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [8:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [8:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    always #5 clk = ~clk;

    axi4_slave_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk(clk), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic [8:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
    } rsp_t;

    rsp_t exp_b[$];
    rsp_t exp_r[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge
    always @(negedge clk) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected", exp_b.size(), 1);
                else begin
                    rsp_t e;
                    e = exp_b.pop_front();
                    check("bid", BID, e.id);
                    check("bresp", BRESP, e.resp);
                end
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) check("r_unexpected", exp_r.size(), 1);
                else begin
                    rsp_t e;
                    e = exp_r.pop_front();
                    check("rid", RID, e.id);
                    check("rresp", RRESP, e.resp);
                    check("rdata", RDATA, e.data);
                    check("rlast", RLAST, e.last);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [8:0] id, input logic [1:0] resp);
        rsp_t e;
        e.id = id; e.resp = resp; e.data = '0; e.last = 1'b1;
        exp_b.push_back(e);
    endtask

    task automatic push_r(input logic [8:0] id, input logic [1:0] resp,
                          input logic [31:0] data, input logic last);
        rsp_t e;
        e.id = id; e.resp = resp; e.data = data; e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic aw_send(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int   n;
        logic hs;
        n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        do begin
            @(negedge clk); hs = AWREADY; cyc(); n++;
        end while (!hs && n < 50);
        if (!hs) check("aw_timeout", hs, 1);
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] base, input logic [3:0] strb, input int nbeats);
        int   n;
        logic hs;
        for (int i = 0; i < nbeats; i++) begin
            n = 0;
            WDATA = base + 32'(i); WSTRB = strb; WLAST = (i == nbeats - 1); WVALID = 1'b1;
            do begin
                @(negedge clk); hs = WREADY; cyc(); n++;
            end while (!hs && n < 50);
            if (!hs) check("w_timeout", hs, 1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic ar_send(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int   n;
        logic hs;
        n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        do begin
            @(negedge clk); hs = ARREADY; cyc(); n++;
        end while (!hs && n < 50);
        if (!hs) check("ar_timeout", hs, 1);
        ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (exp_b.size() != 0 && n < 200) begin cyc(); n++; end
        check("b_drained", exp_b.size(), 0);
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (exp_r.size() != 0 && n < 200) begin cyc(); n++; end
        check("r_drained", exp_r.size(), 0);
    endtask

    task automatic do_write(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [31:0] base,
                            input logic [3:0] strb, input logic [1:0] resp);
        push_b(id, resp);
        aw_send(id, addr, len, 3'd2, burst);
        w_send(base, strb, int'(len) + 1);
        wait_b();
    endtask

    task automatic do_read(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst);
        ar_send(id, addr, len, 3'd2, burst);
        wait_r();
    endtask

    initial begin
        #200000;
        check("watchdog", 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int   n;
        logic seen;
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_wready",  WREADY,  0);
        check("rst_bvalid",  BVALID,  0);
        check("rst_rvalid",  RVALID,  0);
        @(posedge clk); #1 ARESET = 1'b0;
        cyc();
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_arready", ARREADY, 1);

        // INCR write then read back
        do_write(9'h005, 32'h10, 4'd3, 2'b01, 32'hA0, 4'hF, 2'b00);
        push_r(9'h00C, 2'b00, 32'hA0, 1'b0);
        push_r(9'h00C, 2'b00, 32'hA1, 1'b0);
        push_r(9'h00C, 2'b00, 32'hA2, 1'b0);
        push_r(9'h00C, 2'b00, 32'hA3, 1'b1);
        do_read(9'h00C, 32'h10, 4'd3, 2'b01);

        // partial strobe and ID echo
        do_write(9'h1A5, 32'h40, 4'd0, 2'b01, 32'h11223344, 4'hF, 2'b00);
        do_write(9'h1A5, 32'h40, 4'd0, 2'b01, 32'hDEADBEEF, 4'h3, 2'b00);
        push_r(9'h0F3, 2'b00, 32'h1122BEEF, 1'b1);
        do_read(9'h0F3, 32'h40, 4'd0, 2'b01);

        // FIXED burst re-reads the same word
        push_r(9'h002, 2'b00, 32'hA0, 1'b0);
        push_r(9'h002, 2'b00, 32'hA0, 1'b1);
        do_read(9'h002, 32'h10, 4'd1, 2'b00);

        // R stall on beat 2
        push_r(9'h007, 2'b00, 32'hA0, 1'b0);
        push_r(9'h007, 2'b00, 32'hA1, 1'b0);
        push_r(9'h007, 2'b00, 32'hA2, 1'b0);
        push_r(9'h007, 2'b00, 32'hA3, 1'b1);
        ar_send(9'h007, 32'h10, 4'd3, 3'd2, 2'b01);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk); seen = RVALID && RREADY; n++;
        end
        check("r_first_beat_seen", seen, 1);
        cyc(); RREADY = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rstall_rvalid", RVALID, 1);
            check("rstall_rdata",  RDATA,  32'hA1);
            check("rstall_rlast",  RLAST,  0);
        end
        cyc(); RREADY = 1'b1;
        wait_r();

        // B stall for 10 cycles
        BREADY = 1'b0;
        push_b(9'h033, 2'b00);
        aw_send(9'h033, 32'h80, 4'd0, 3'd2, 2'b01);
        w_send(32'h77, 4'hF, 1);
        n = 0;
        while (!BVALID && n < 50) begin cyc(); n++; end
        repeat (10) begin
            @(negedge clk);
            check("bstall_bvalid", BVALID, 1);
            check("bstall_bresp",  BRESP,  2'b00);
            check("bstall_bid",    BID,    9'h033);
        end
        cyc(); BREADY = 1'b1;
        wait_b();

        // out-of-range write/read
        do_write(9'h001, 32'h0, 4'd0, 2'b01, 32'h0BADF00D, 4'hF, 2'b00);
        do_write(9'h002, 32'(MEM_DEPTH * 4), 4'd0, 2'b01, 32'h55555555, 4'hF, 2'b10);
        push_r(9'h003, 2'b00, 32'h0BADF00D, 1'b1);
        do_read(9'h003, 32'h0, 4'd0, 2'b01);
        push_r(9'h004, 2'b10, 32'h0, 1'b1);
        do_read(9'h004, 32'(MEM_DEPTH * 4), 4'd0, 2'b01);

        // reserved burst type
        push_r(9'h005, 2'b10, 32'h0, 1'b0);
        push_r(9'h005, 2'b10, 32'h0, 1'b1);
        do_read(9'h005, 32'h10, 4'd1, 2'b11);
        do_write(9'h006, 32'h10, 4'd0, 2'b11, 32'h12345678, 4'hF, 2'b10);
        push_r(9'h006, 2'b00, 32'hA0, 1'b1);
        do_read(9'h006, 32'h10, 4'd0, 2'b01);

        // WRAP read from 0x38 across a 16-byte window
        do_write(9'h007, 32'h30, 4'd3, 2'b01, 32'hC0, 4'hF, 2'b00);
`ifdef AXI_SLV_WRAP_BURST_EN
        push_r(9'h008, 2'b00, 32'hC2, 1'b0);
        push_r(9'h008, 2'b00, 32'hC3, 1'b0);
        push_r(9'h008, 2'b00, 32'hC0, 1'b0);
        push_r(9'h008, 2'b00, 32'hC1, 1'b1);
`else
        push_r(9'h008, 2'b10, 32'h0, 1'b0);
        push_r(9'h008, 2'b10, 32'h0, 1'b0);
        push_r(9'h008, 2'b10, 32'h0, 1'b0);
        push_r(9'h008, 2'b10, 32'h0, 1'b1);
`endif
        do_read(9'h008, 32'h38, 4'd3, 2'b10);

        // reset during beat 2 of an 8-beat read
        push_r(9'h009, 2'b00, 32'hA0, 1'b0);
        ar_send(9'h009, 32'h10, 4'd7, 3'd2, 2'b01);
        wait_r();
        RREADY = 1'b0; ARESET = 1'b1;
        cyc();
        check("mid_rst_rvalid",  RVALID,  0);
        check("mid_rst_arready", ARREADY, 0);
        cyc();
        check("mid_rst_arready_hold", ARREADY, 0);
        ARESET = 1'b0; RREADY = 1'b1;
        cyc();
        check("rel_arready", ARREADY, 1);
        check("rel_rvalid",  RVALID,  0);
        push_r(9'h00A, 2'b00, 32'hA0, 1'b1);
        do_read(9'h00A, 32'h10, 4'd0, 2'b01);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
